// File: rtl/ooo_hu_pkg.sv
// Shared types for the multi-lane OoO issue hazard unit.
// Build option OOO_HU_WAW_RENAME_EN is consumed by ooo_issue_hazard_unit.
package ooo_hu_pkg;
    localparam int HU_NUM_REGS = 32;

    typedef enum logic [1:0] {
        CSR_IDLE,
        CSR_DRAIN,
        CSR_ISSUE,
        CSR_WAIT
    } csr_state_t;

    typedef enum logic [2:0] {
        FU_ALU       = 3'd0,
        FU_MUL       = 3'd1,
        FU_DIV       = 3'd2,
        FU_LOADSTORE = 3'd3,
        FU_BRANCH    = 3'd4,
        FU_CSR       = 3'd5
    } fu_type_t;

    function automatic int hu_tag_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/ooo_hu_scoreboard.sv
// Tagged register scoreboard: busy bit plus producing ROB tag per register.
// Read ports report busy with same-cycle writeback already applied.
module ooo_hu_scoreboard
    import ooo_hu_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int NUM_WB  = 2,
    parameter int TW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ISSUE_W-1:0]    iss_en,
    input  logic [ISSUE_W*5-1:0]  iss_rd,
    input  logic [ISSUE_W*TW-1:0] iss_tag,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [NUM_WB*5-1:0]   wb_rd,
    input  logic [NUM_WB*TW-1:0]  wb_tag,
    input  logic [ISSUE_W*5-1:0]  rs1,
    input  logic [ISSUE_W*5-1:0]  rs2,
    input  logic [ISSUE_W*5-1:0]  rd,
    output logic [ISSUE_W-1:0]    rs1_busy,
    output logic [ISSUE_W-1:0]    rs2_busy,
    output logic [ISSUE_W-1:0]    rd_busy
);
    logic [HU_NUM_REGS-1:0] busy, busy_n, wb_clr, eff;
    logic [TW-1:0]          tag   [HU_NUM_REGS];
    logic [TW-1:0]          tag_n [HU_NUM_REGS];
    logic [4:0]             ird;

    // A writeback only clears the register if it carries the newest tag.
    always_comb begin
        wb_clr = '0;
        for (int r = 1; r < HU_NUM_REGS; r++)
            for (int p = 0; p < NUM_WB; p++)
                if (wb_valid[p] && wb_rd[p*5 +: 5] == 5'(r) &&
                    wb_tag[p*TW +: TW] == tag[r])
                    wb_clr[r] = 1'b1;
    end

    assign eff = busy & ~wb_clr;

    always_comb begin
        for (int j = 0; j < ISSUE_W; j++) begin
            rs1_busy[j] = eff[rs1[j*5 +: 5]];
            rs2_busy[j] = eff[rs2[j*5 +: 5]];
            rd_busy[j]  = eff[rd[j*5 +: 5]];
        end
    end

    always_comb begin
        busy_n = eff;
        ird    = '0;
        for (int r = 0; r < HU_NUM_REGS; r++)
            tag_n[r] = tag[r];
        for (int j = 0; j < ISSUE_W; j++) begin
            ird = iss_rd[j*5 +: 5];
            if (iss_en[j] && ird != 5'd0) begin
                busy_n[ird] = 1'b1;
                tag_n[ird]  = iss_tag[j*TW +: TW];
            end
        end
        if (flush)
            busy_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int r = 0; r < HU_NUM_REGS; r++)
                tag[r] <= '0;
        end else begin
            busy <= busy_n;
            for (int r = 0; r < HU_NUM_REGS; r++)
                tag[r] <= tag_n[r];
        end
    end
endmodule

// File: rtl/ooo_issue_hazard_unit.sv
// Multi-lane in-order issue hazard unit with scoreboard, FU limits, CSR FSM.
// Define OOO_HU_WAW_RENAME_EN to let busy destinations rename instead of stall.
module ooo_issue_hazard_unit
    import ooo_hu_pkg::*;
#(
    parameter int ISSUE_W   = 2,
    parameter int NUM_WB    = 2,
    parameter int ROB_DEPTH = 16,
    parameter int LS_MAX    = 4,
    parameter int TW        = hu_tag_w(ROB_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ISSUE_W-1:0]    dec_valid,
    input  logic [ISSUE_W*5-1:0]  dec_rs1,
    input  logic [ISSUE_W*5-1:0]  dec_rs2,
    input  logic [ISSUE_W-1:0]    dec_rs1_used,
    input  logic [ISSUE_W-1:0]    dec_rs2_used,
    input  logic [ISSUE_W*5-1:0]  dec_rd,
    input  logic [ISSUE_W-1:0]    dec_wen,
    input  logic [ISSUE_W*3-1:0]  dec_fu,
    input  logic [ISSUE_W-1:0]    dec_store,
    input  logic [ISSUE_W-1:0]    dec_csr,
    input  logic [ISSUE_W*TW-1:0] dec_tag,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [NUM_WB*5-1:0]   wb_rd,
    input  logic [NUM_WB*TW-1:0]  wb_tag,
    input  logic                  ls_done,
    input  logic                  div_done,
    input  logic                  csr_done,
    input  logic                  rob_full,
    input  logic                  rob_empty,
    input  logic                  i_mem_busy,
    input  logic                  mispredict,
    input  logic                  insert_priv_pc,
    output logic [ISSUE_W-1:0]    issue_ok,
    output logic                  pc_en,
    output logic                  stall_fetch_decode,
    output logic                  fetch_decode_flush,
    output logic                  decode_execute_flush
);
    localparam int CW = $clog2(LS_MAX + 1);

    csr_state_t         csr_st, csr_n;
    logic [CW-1:0]      ls_cnt, ls_cnt_n;
    logic               div_busy, div_busy_n, div_free, div_iss;
    logic               redirect, raw, div_old, any_old, chain;
    logic [ISSUE_W-1:0] b1, b2, bd, waw, haz;
    int                 ls_eff, ls_old, ls_iss, ls_tmp;
    fu_type_t           fu_i, fu_j;
    logic [4:0]         rd_i;

    assign redirect = mispredict | insert_priv_pc;
    assign ls_eff   = int'(ls_cnt) - ((ls_done && ls_cnt != '0) ? 1 : 0);
    assign div_free = ~div_busy | div_done;

    ooo_hu_scoreboard #(.ISSUE_W(ISSUE_W), .NUM_WB(NUM_WB), .TW(TW)) u_sb (
        .clk(clk), .rst(rst), .flush(redirect),
        .iss_en(issue_ok & dec_wen), .iss_rd(dec_rd), .iss_tag(dec_tag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .rs1(dec_rs1), .rs2(dec_rs2), .rd(dec_rd),
        .rs1_busy(b1), .rs2_busy(b2), .rd_busy(bd)
    );

`ifdef OOO_HU_WAW_RENAME_EN
    assign waw = '0;
`else
    assign waw = dec_wen & bd;
`endif

    // Older lanes only matter if valid: a lane issues only if all older lanes do.
    always_comb begin
        haz = '0; raw = 1'b0; div_old = 1'b0; any_old = 1'b0; ls_old = 0;
        fu_i = FU_ALU; fu_j = FU_ALU; rd_i = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            raw = 1'b0; div_old = 1'b0; any_old = 1'b0; ls_old = 0;
            fu_j = fu_type_t'(dec_fu[j*3 +: 3]);
            for (int i = 0; i < ISSUE_W; i++) begin
                fu_i = fu_type_t'(dec_fu[i*3 +: 3]);
                rd_i = dec_rd[i*5 +: 5];
                if (i < j && dec_valid[i]) begin
                    any_old = 1'b1;
                    if (dec_wen[i] && rd_i != 5'd0 &&
                        ((dec_rs1_used[j] && rd_i == dec_rs1[j*5 +: 5]) ||
                         (dec_rs2_used[j] && rd_i == dec_rs2[j*5 +: 5])))
                        raw = 1'b1;
                    if (fu_i == FU_DIV) div_old = 1'b1;
                    if (fu_i == FU_LOADSTORE) ls_old++;
                end
            end
            haz[j] = (dec_rs1_used[j] & b1[j]) | (dec_rs2_used[j] & b2[j])
                   | raw | waw[j]
                   | ((fu_j == FU_DIV) & (~div_free | div_old))
                   | ((fu_j == FU_LOADSTORE) & (ls_eff + ls_old >= LS_MAX))
                   | (dec_store[j] & (~rob_empty | any_old))
                   | (dec_csr[j] & ((j != 0) | (csr_st == CSR_IDLE)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_st   <= CSR_IDLE;
            ls_cnt   <= '0;
            div_busy <= 1'b0;
        end else begin
            csr_st   <= csr_n;
            ls_cnt   <= ls_cnt_n;
            div_busy <= div_busy_n;
        end
    end

    always_comb begin
        csr_n = csr_st;
        unique case (csr_st)
            CSR_IDLE:  if (dec_valid[0] && dec_csr[0]) csr_n = CSR_DRAIN;
            CSR_DRAIN: if (rob_empty) csr_n = CSR_ISSUE;
            CSR_ISSUE: csr_n = CSR_WAIT;
            CSR_WAIT:  if (csr_done) csr_n = CSR_IDLE;
            default:   csr_n = CSR_IDLE;
        endcase
        if (redirect)
            csr_n = CSR_IDLE;
    end

    always_comb begin
        issue_ok = '0;
        chain    = 1'b1;
        if (!redirect && csr_st == CSR_ISSUE) begin
            issue_ok[0] = dec_valid[0] & dec_csr[0];
        end else if (!redirect && !rob_full && csr_st == CSR_IDLE) begin
            for (int j = 0; j < ISSUE_W; j++) begin
                chain       = chain & dec_valid[j] & ~haz[j];
                issue_ok[j] = chain;
            end
        end
    end

    // A redirect reloads the PC, so fetch must not be held that cycle.
    assign stall_fetch_decode = ~redirect &
        (~&(issue_ok | ~dec_valid) | rob_full | (csr_st != CSR_IDLE));
    assign pc_en                = ~(i_mem_busy | stall_fetch_decode);
    assign fetch_decode_flush   = redirect | csr_done;
    assign decode_execute_flush = redirect | csr_done;

    always_comb begin
        ls_iss  = 0;
        div_iss = 1'b0;
        for (int j = 0; j < ISSUE_W; j++)
            if (issue_ok[j]) begin
                if (fu_type_t'(dec_fu[j*3 +: 3]) == FU_LOADSTORE) ls_iss++;
                if (fu_type_t'(dec_fu[j*3 +: 3]) == FU_DIV) div_iss = 1'b1;
            end
        ls_tmp = ls_eff + ls_iss;
        if (ls_tmp > LS_MAX) ls_tmp = LS_MAX;
        if (ls_tmp < 0) ls_tmp = 0;
        ls_cnt_n   = redirect ? '0 : CW'(ls_tmp);
        div_busy_n = ~redirect & (div_iss | (div_busy & ~div_done));
    end
endmodule

// File: tb/tb_ooo_issue_hazard_unit.sv
// Directed scoreboard bench for ooo_issue_hazard_unit (2 lanes, LS_MAX=4).
// Expected outputs are queued at drive time and checked on the falling edge.
module tb_ooo_issue_hazard_unit;
    import ooo_hu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dec_valid, dec_rs1_used, dec_rs2_used, dec_wen;
    logic [1:0] dec_store, dec_csr, wb_valid, issue_ok;
    logic [9:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
    logic [5:0] dec_fu;
    logic [7:0] dec_tag, wb_tag;
    logic       ls_done, div_done, csr_done, rob_full, rob_empty;
    logic       i_mem_busy, mispredict, insert_priv_pc;
    logic       pc_en, stall_fetch_decode;
    logic       fetch_decode_flush, decode_execute_flush;

    typedef struct packed {
        logic [1:0] iok;
        logic       stall;
        logic       pc;
        logic       fl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ooo_issue_hazard_unit dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_wen(dec_wen), .dec_fu(dec_fu),
        .dec_store(dec_store), .dec_csr(dec_csr), .dec_tag(dec_tag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .ls_done(ls_done), .div_done(div_done), .csr_done(csr_done),
        .rob_full(rob_full), .rob_empty(rob_empty), .i_mem_busy(i_mem_busy),
        .mispredict(mispredict), .insert_priv_pc(insert_priv_pc),
        .issue_ok(issue_ok), .pc_en(pc_en),
        .stall_fetch_decode(stall_fetch_decode),
        .fetch_decode_flush(fetch_decode_flush),
        .decode_execute_flush(decode_execute_flush)
    );

    task automatic idle();
        dec_valid = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = '0;
        dec_rs2_used = '0; dec_rd = '0; dec_wen = '0; dec_fu = '0;
        dec_store = '0; dec_csr = '0; dec_tag = '0;
        wb_valid = '0; wb_rd = '0; wb_tag = '0;
        ls_done = 0; div_done = 0; csr_done = 0; rob_full = 0;
        rob_empty = 1; i_mem_busy = 0; mispredict = 0; insert_priv_pc = 0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic wen,
                            input fu_type_t fu, input logic st,
                            input logic cs, input logic [3:0] tg);
        dec_valid[l] = 1'b1;
        dec_rs1[l*5 +: 5] = rs1; dec_rs1_used[l] = u1;
        dec_rs2[l*5 +: 5] = rs2; dec_rs2_used[l] = u2;
        dec_rd[l*5 +: 5] = rd;   dec_wen[l] = wen;
        dec_fu[l*3 +: 3] = fu;   dec_store[l] = st;
        dec_csr[l] = cs;         dec_tag[l*4 +: 4] = tg;
    endtask

    task automatic set_wb(input int p, input logic [4:0] rd, input logic [3:0] tg);
        wb_valid[p] = 1'b1; wb_rd[p*5 +: 5] = rd; wb_tag[p*4 +: 4] = tg;
    endtask

    task automatic chk(input string nm, input logic [1:0] iok, input logic st,
                       input logic pc, input logic fl);
        exp_t e;
        q.push_back('{iok: iok, stall: st, pc: pc, fl: fl});
        @(negedge clk);
        e = q.pop_front();
        total++;
        assert (issue_ok === e.iok) else begin
            bad++; $error("FAIL %s issue_ok got=%b want=%b", nm, issue_ok, e.iok);
        end
        total++;
        assert (stall_fetch_decode === e.stall) else begin
            bad++; $error("FAIL %s stall got=%b want=%b", nm, stall_fetch_decode, e.stall);
        end
        total++;
        assert (pc_en === e.pc) else begin
            bad++; $error("FAIL %s pc_en got=%b want=%b", nm, pc_en, e.pc);
        end
        total++;
        assert (fetch_decode_flush === e.fl) else begin
            bad++; $error("FAIL %s fd_flush got=%b want=%b", nm, fetch_decode_flush, e.fl);
        end
        total++;
        assert (decode_execute_flush === e.fl) else begin
            bad++; $error("FAIL %s de_flush got=%b want=%b", nm, decode_execute_flush, e.fl);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        chk("reset", 2'b00, 0, 1, 0);
        cyc();
        rst = 1'b0;

        // writeback bypass
        idle(); set_lane(0, 0,0, 0,0, 5,1, FU_ALU,0,0, 3);
        chk("wr_x5", 2'b01, 0, 1, 0); cyc();
        idle(); set_lane(0, 5,1, 0,0, 0,0, FU_ALU,0,0, 0);
        chk("raw_x5", 2'b00, 1, 0, 0); cyc();
        idle(); set_lane(0, 5,1, 0,0, 6,1, FU_ALU,0,0, 4); set_wb(0, 5, 3);
        chk("wb_bypass", 2'b01, 0, 1, 0); cyc();
        idle(); set_lane(0, 5,1, 0,0, 0,0, FU_ALU,0,0, 0);
        chk("x5_clear", 2'b01, 0, 1, 0); cyc();

        // intra-bundle RAW
        idle(); set_lane(0, 0,0, 0,0, 7,1, FU_ALU,0,0, 5);
        set_lane(1, 7,1, 0,0, 8,1, FU_ALU,0,0, 6);
        chk("bundle_raw", 2'b01, 1, 0, 0); cyc();
        idle(); set_lane(0, 7,1, 0,0, 8,1, FU_ALU,0,0, 6); set_wb(1, 7, 5);
        chk("raw_release", 2'b01, 0, 1, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 0,1, FU_ALU,0,0, 1);
        set_lane(1, 0,1, 0,1, 0,0, FU_ALU,0,0, 2);
        chk("x0_nohaz", 2'b11, 0, 1, 0); cyc();

        // stale writeback
        idle(); set_lane(0, 6,1, 0,0, 0,0, FU_ALU,0,0, 0); set_wb(0, 6, 9);
        chk("stale_wb", 2'b00, 1, 0, 0); cyc();
        idle(); set_lane(0, 6,1, 0,0, 0,0, FU_ALU,0,0, 0);
        chk("stale_kept", 2'b00, 1, 0, 0); cyc();
        idle(); set_wb(0, 6, 4);
        chk("wb_clear_idle", 2'b00, 0, 1, 0); cyc();
        idle(); set_lane(0, 0,0, 6,1, 0,0, FU_ALU,0,0, 0); i_mem_busy = 1;
        chk("imem_busy", 2'b01, 0, 0, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 8,1, FU_ALU,0,0, 2);
`ifdef OOO_HU_WAW_RENAME_EN
        chk("waw", 2'b01, 0, 1, 0); cyc();
`else
        chk("waw", 2'b00, 1, 0, 0); cyc();
`endif
        idle(); set_lane(0, 0,0, 0,0, 9,1, FU_ALU,0,0, 1); rob_full = 1;
        chk("rob_full", 2'b00, 1, 0, 0); cyc();

        // CSR serialisation
        idle(); set_lane(0, 0,0, 0,0, 20,1, FU_CSR,0,1, 7); rob_empty = 0;
        chk("csr_idle", 2'b00, 1, 0, 0); cyc();
        for (int k = 0; k < 3; k++) begin
            idle(); set_lane(0, 0,0, 0,0, 20,1, FU_CSR,0,1, 7); rob_empty = 0;
            chk("csr_drain", 2'b00, 1, 0, 0); cyc();
        end
        idle(); set_lane(0, 0,0, 0,0, 20,1, FU_CSR,0,1, 7);
        chk("csr_drain_done", 2'b00, 1, 0, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 20,1, FU_CSR,0,1, 7);
        chk("csr_issue", 2'b01, 1, 0, 0); cyc();
        idle();
        chk("csr_wait", 2'b00, 1, 0, 0); cyc();
        idle(); csr_done = 1;
        chk("csr_done", 2'b00, 1, 0, 1); cyc();
        idle(); set_lane(0, 0,0, 0,0, 24,1, FU_ALU,0,0, 1);
        set_lane(1, 0,0, 0,0, 25,1, FU_CSR,0,1, 2);
        chk("csr_lane1", 2'b01, 1, 0, 0); cyc();

        // load/store limit
        idle(); set_lane(0, 0,0, 0,0, 10,1, FU_LOADSTORE,0,0, 1);
        set_lane(1, 0,0, 0,0, 11,1, FU_LOADSTORE,0,0, 2);
        chk("ls_pair1", 2'b11, 0, 1, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 12,1, FU_LOADSTORE,0,0, 3);
        set_lane(1, 0,0, 0,0, 13,1, FU_LOADSTORE,0,0, 4);
        chk("ls_pair2", 2'b11, 0, 1, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 14,1, FU_LOADSTORE,0,0, 5);
        chk("ls_full", 2'b00, 1, 0, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 14,1, FU_LOADSTORE,0,0, 5); ls_done = 1;
        chk("ls_done_bypass", 2'b01, 0, 1, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 15,1, FU_ALU,0,0, 6);
        set_lane(1, 0,0, 0,0, 16,1, FU_LOADSTORE,0,0, 7);
        chk("ls_lane1_stall", 2'b01, 1, 0, 0); cyc();

        // divider and flush
        idle(); set_lane(0, 0,0, 0,0, 21,1, FU_DIV,0,0, 8);
        chk("div_issue", 2'b01, 0, 1, 0); cyc();
        idle(); set_lane(0, 0,0, 0,0, 22,1, FU_DIV,0,0, 9);
        chk("div_busy", 2'b00, 1, 0, 0); cyc();
        idle(); set_lane(0, 21,1, 0,0, 22,1, FU_DIV,0,0, 9); mispredict = 1;
        chk("mispredict", 2'b00, 0, 1, 1); cyc();
        idle(); set_lane(0, 21,1, 0,0, 22,1, FU_DIV,0,0, 9);
        set_lane(1, 0,0, 10,1, 23,1, FU_LOADSTORE,0,0, 10);
        chk("post_flush", 2'b11, 0, 1, 0); cyc();
        idle(); set_lane(0, 22,1, 0,0, 0,0, FU_ALU,0,0, 0); insert_priv_pc = 1;
        chk("priv_redirect", 2'b00, 0, 1, 1); cyc();
        idle(); set_lane(0, 22,1, 0,0, 0,0, FU_ALU,0,0, 0);
        chk("after_priv", 2'b01, 0, 1, 0); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
